fma_issue_queue: RTL and testbench
==================================

Name: fma_issue_queue

Overview:
- Issue queue on the producer side of the FMA lane's issue interface.
- Buffers dispatched FP arithmetic micro-ops, tracks source-operand readiness from wakeup broadcasts, and issues one ready op per cycle, oldest first.
- Enforces the FMA lane's fixed writeback latencies so no two issued ops reach the single writeback port in the same cycle.
- Sits between rename/dispatch and the FMA lane; register-file read occurs one stage after issue, outside this block.

Parameters:
- DEPTH, 8, number of queue entries (power of two, ≥2).
- WAKE_NUM, 4, number of external wakeup ports.
- LAT_ADD, 1, cycles from issue to writeback for FLT_ADD/FLT_SUB.
- LAT_MUL, 2, cycles from issue to writeback for FLT_MUL.
- LAT_MADD, 4, cycles from issue to writeback for FLT_MADD/MSUB/NMSUB/NMADD.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- dis_en  in  1  dispatch valid.
- dis_ready  out  1  queue can accept; high when at least one entry is free.
- dis_fltop  in  `FLTOP_WIDTH  operation.
- dis_rm  in  3  rounding mode field.
- dis_rs1/dis_rs2/dis_rs3  in  `PREG_WIDTH each  source pregs.
- dis_rdy  in  3  per-source ready at dispatch.
- dis_rd  in  `PREG_WIDTH  destination preg.
- dis_robIdx  in  `ROB_WIDTH  ROB index.
- wake_en  in  WAKE_NUM  external wakeup valid.
- wake_rd  in  WAKE_NUM×`PREG_WIDTH  woken pregs.
- backendCtrl  in  BackendCtrl  redirect and redirectIdx.
- iss_en  out  1  issue valid.
- iss_fltop, iss_rm, iss_rs1, iss_rs2, iss_rs3, iss_rd, iss_robIdx  out  same widths as the dis_* fields  issued op fields.

Behaviour:
- Reset: all entries invalid; age matrix cleared; reservation register zero; iss_en=0 and all iss_* fields 0; dis_ready=1.
- Enqueue:
  - On dis_en && dis_ready, write the lowest-index free entry.
  - An entry's source ready bit is set if dis_rdy[i] is set, or if any same-cycle wake_en/wake_rd matches that source (bypass).
  - The new entry becomes younger than every valid entry.
- Wakeup: each cycle, any valid entry source equal to an asserted wake_rd sets its ready bit. Ready bits are sticky until the entry is freed. rs3 is only relevant for MADD-class ops; it is forced ready at dispatch for other ops.
- Readiness: an entry is eligible when valid, all needed sources are ready, and wb_rsv[L(op)-1]==0, where L is the op's latency.
- Reservation register: wb_rsv is LAT_MADD bits. Bit k means the writeback port is busy k+1 cycles from now.
  - Each cycle wb_rsv shifts toward bit 0.
  - On issue, bit L-1 of the post-shift vector is set.
  - The same rule also covers the internal adder-input sharing between ADD and a MADD issued 3 cycles earlier.
- Select:
  - Among eligible entries, pick the one that is oldest per the age matrix.
  - Registered output: the selection made in cycle t drives iss_* in cycle t+1.
  - The entry is freed at selection (cycle t); its slot may be re-dispatched in t+1.
  - Unknown fltop is treated as LAT_ADD.
- Internal wakeup: a selected op's rd is not broadcast by this block; the FMA lane's wakeup output returns through wake_en/wake_rd.
- Redirect: when backendCtrl.redirect is high, every entry whose robIdx is squashed per LoopCompare(redirectIdx, robIdx) is invalidated that cycle.
  - A candidate selected that cycle is suppressed: iss_en=0 next cycle, and no reservation is set.
  - Dispatch in a redirect cycle is ignored.
  - wb_rsv is not cleared by redirect; the downstream lane squashes its own in-flight ops.
- Full: dis_ready=0 when all DEPTH entries are valid. Simultaneous issue and dispatch when full is not allowed; dis_ready is computed from current occupancy only.
- Empty: iss_en=0 next cycle.
- Simultaneous events: dispatch, wakeup, select and redirect may all occur in one cycle, with priority redirect > select > wakeup > enqueue on the same entry.

Decomposition:
- Shared package (or defines header): FLT op encodings, `FLTOP_WIDTH, a fma_latency() function mapping fltop to LAT, and an FmaIQEntry typedef holding op fields, src pregs, ready bits, rd and robIdx.
- One sub-module, age_matrix_select (DEPTH): update on enqueue, free on dequeue, outputs a one-hot oldest among an eligible mask.

Test Plan:
- Reset then idle 5 cycles -> iss_en=0, dis_ready=1, no spurious issue.
- Dispatch MUL (rs1=5, rs2=6 ready), next cycle ADD (ready) -> MUL issued cycle t+1. ADD is blocked at t+1 because its writeback would collide at MUL's t+3, then issues at t+2.
- Dispatch MADD with rs3=9 not ready; wake_rd=9 in cycle 3 -> issue at cycle 4 with iss_rs3=9. An ADD ready at cycle 6 is held one cycle (writeback at cycle 9 is reserved).
- Fill 8 entries with all sources not ready -> dis_ready=0. A wakeup of all sources -> issue in dispatch (age) order robIdx 0..7, one per cycle, with dis_ready returning to 1 after the first issue.
- Entries with robIdx 2,4,6 queued, redirect with redirectIdx=3 -> entries 4 and 6 invalidated; only robIdx 2 ever issues.
- Same-cycle dispatch of rs1=12 (not ready) with wake_rd=12 -> entry ready immediately and issues the following cycle.

Source files
------------

// File: rtl/fma_issue_queue_pkg.sv
// Shared definitions for the FMA issue queue.
// - fltop_e      : FP arithmetic op encodings
// - BackendCtrl  : redirect request (valid + ROB index of the redirecting op)
// - FmaIssue     : op fields carried from dispatch to issue
// - FmaIQEntry   : one queue slot (op fields + per-source ready bits)
// - fma_latency  : issue-to-writeback latency of an op
// - loop_compare : wrap-aware "rob_idx is younger than redirect_idx"
package fma_issue_queue_pkg;

  localparam int FLTOP_WIDTH = 4;
  localparam int PREG_WIDTH  = 6;
  localparam int ROB_WIDTH   = 6;

  typedef enum logic [FLTOP_WIDTH-1:0] {
    FLT_ADD   = 4'd0,
    FLT_SUB   = 4'd1,
    FLT_MUL   = 4'd2,
    FLT_MADD  = 4'd3,
    FLT_MSUB  = 4'd4,
    FLT_NMSUB = 4'd5,
    FLT_NMADD = 4'd6
  } fltop_e;

  typedef struct packed {
    logic                 redirect;
    logic [ROB_WIDTH-1:0] redirectIdx;
  } BackendCtrl;

  typedef struct packed {
    logic [FLTOP_WIDTH-1:0] fltop;
    logic [2:0]             rm;
    logic [PREG_WIDTH-1:0]  rs1;
    logic [PREG_WIDTH-1:0]  rs2;
    logic [PREG_WIDTH-1:0]  rs3;
    logic [PREG_WIDTH-1:0]  rd;
    logic [ROB_WIDTH-1:0]   robIdx;
  } FmaIssue;

  // rdy[0]=rs1, rdy[1]=rs2, rdy[2]=rs3
  typedef struct packed {
    FmaIssue    uop;
    logic [2:0] rdy;
  } FmaIQEntry;

  function automatic logic is_madd_class(input logic [FLTOP_WIDTH-1:0] op);
    return (op == FLT_MADD) || (op == FLT_MSUB) || (op == FLT_NMSUB) || (op == FLT_NMADD);
  endfunction

  // Unknown encodings fall back to the adder latency.
  function automatic int unsigned fma_latency(input logic [FLTOP_WIDTH-1:0] op,
                                              input int unsigned lat_add,
                                              input int unsigned lat_mul,
                                              input int unsigned lat_madd);
    if (op == FLT_MUL) return lat_mul;
    if (is_madd_class(op)) return lat_madd;
    return lat_add;
  endfunction

  // True when rob_idx lies strictly after redirect_idx in the circular ROB
  // order (distance in the lower half of the index space).
  function automatic logic loop_compare(input logic [ROB_WIDTH-1:0] redirect_idx,
                                        input logic [ROB_WIDTH-1:0] rob_idx);
    logic [ROB_WIDTH-1:0] diff;
    diff = rob_idx - redirect_idx;
    return (diff != '0) && !diff[ROB_WIDTH-1];
  endfunction

endpackage

// File: rtl/fma_issue_queue_age_matrix_select.sv
// Age matrix with oldest-eligible select.
// - clk, rst   : clock, synchronous active-high reset
// - enq_en     : an entry is written this cycle at slot enq_oh (one-hot)
// - free_mask  : slots released this cycle
// - valid      : current slot occupancy
// - elig       : slots that may be selected this cycle
// - oldest_oh  : one-hot of the oldest eligible slot (zero if none)
module age_matrix_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_en,
  input  logic [DEPTH-1:0] enq_oh,
  input  logic [DEPTH-1:0] free_mask,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] oldest_oh
);

  // age_q[i][j] = 1 : slot i is older than slot j
  logic [DEPTH-1:0] age_q [DEPTH];
  // older_than[i][j] = 1 : slot j is older than slot i
  logic [DEPTH-1:0] older_than [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (enq_en && enq_oh[j])
            // every surviving entry is older than the newcomer
            age_q[i][j] <= valid[i] & ~free_mask[i];
          else if (enq_en && enq_oh[i])
            age_q[i][j] <= 1'b0;
          else if (free_mask[i] || free_mask[j])
            age_q[i][j] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
        assign older_than[gi][gj] = age_q[gj][gi];
      end
      assign oldest_oh[gi] = elig[gi] & ~|(elig & older_than[gi]);
    end
  endgenerate

endmodule

// File: rtl/fma_issue_queue.sv
// FMA lane issue queue: buffers dispatched FP ops, tracks operand readiness
// from wakeup broadcasts and issues the oldest ready op each cycle while
// keeping writebacks on the single result port from colliding.
// - clk, rst        : clock, synchronous active-high reset
// - dis_*           : dispatch request and op fields; dis_ready = free slot
// - wake_en/wake_rd : external wakeup ports (WAKE_NUM pregs, flattened)
// - backendCtrl     : redirect request squashing younger ops
// - iss_*           : registered issue output (one op per cycle)
module fma_issue_queue
  import fma_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WAKE_NUM = 4,
  parameter int LAT_ADD  = 1,
  parameter int LAT_MUL  = 2,
  parameter int LAT_MADD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dis_en,
  output logic                         dis_ready,
  input  logic [FLTOP_WIDTH-1:0]       dis_fltop,
  input  logic [2:0]                   dis_rm,
  input  logic [PREG_WIDTH-1:0]        dis_rs1,
  input  logic [PREG_WIDTH-1:0]        dis_rs2,
  input  logic [PREG_WIDTH-1:0]        dis_rs3,
  input  logic [2:0]                   dis_rdy,
  input  logic [PREG_WIDTH-1:0]        dis_rd,
  input  logic [ROB_WIDTH-1:0]         dis_robIdx,
  input  logic [WAKE_NUM-1:0]          wake_en,
  input  logic [WAKE_NUM*PREG_WIDTH-1:0] wake_rd,
  input  BackendCtrl                   backendCtrl,
  output logic                         iss_en,
  output logic [FLTOP_WIDTH-1:0]       iss_fltop,
  output logic [2:0]                   iss_rm,
  output logic [PREG_WIDTH-1:0]        iss_rs1,
  output logic [PREG_WIDTH-1:0]        iss_rs2,
  output logic [PREG_WIDTH-1:0]        iss_rs3,
  output logic [PREG_WIDTH-1:0]        iss_rd,
  output logic [ROB_WIDTH-1:0]         iss_robIdx
);

  FmaIQEntry              entry_q [DEPTH];
  FmaIQEntry              entry_d [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [LAT_MADD-1:0]    wb_rsv_q, wb_rsv_d, wb_rsv_shift;
  logic                   iss_en_q;
  FmaIssue                iss_q;

  logic [PREG_WIDTH-1:0]  wake_rd_a [WAKE_NUM];
  logic [2:0]             wake_hit [DEPTH];
  logic [2:0]             dis_wake;
  logic [LAT_MADD-1:0]    lat_oh [DEPTH];
  logic [DEPTH-1:0]       elig, squash, oldest_oh, free_oh, free_mask;
  logic                   enq_fire, issue, sel_squash;
  FmaIssue                sel_uop;
  logic [LAT_MADD-1:0]    rsv_set;
  FmaIQEntry              new_entry;

  assign dis_ready    = ~&valid_q;
  assign enq_fire     = dis_en & dis_ready & ~backendCtrl.redirect;
  // lowest clear bit of valid_q
  assign free_oh      = ~valid_q & (valid_q + DEPTH'(1));
  // eligibility and the new reservation both use the already-advanced vector
  assign wb_rsv_shift = wb_rsv_q >> 1;

  generate
    for (genvar gi = 0; gi < WAKE_NUM; gi++) begin : g_wake
      assign wake_rd_a[gi] = wake_rd[gi*PREG_WIDTH +: PREG_WIDTH];
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign lat_oh[gi] = LAT_MADD'(1) << (fma_latency(entry_q[gi].uop.fltop,
                                                       LAT_ADD, LAT_MUL, LAT_MADD) - 1);
      assign elig[gi]   = valid_q[gi] & (&entry_q[gi].rdy) & ~|(lat_oh[gi] & wb_rsv_shift);
      assign squash[gi] = valid_q[gi] & backendCtrl.redirect &
                          loop_compare(backendCtrl.redirectIdx, entry_q[gi].uop.robIdx);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) wake_hit[i] = '0;
    dis_wake = '0;
    for (int k = 0; k < WAKE_NUM; k++) begin
      if (wake_en[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          wake_hit[i] |= {entry_q[i].uop.rs3 == wake_rd_a[k],
                          entry_q[i].uop.rs2 == wake_rd_a[k],
                          entry_q[i].uop.rs1 == wake_rd_a[k]};
        end
        dis_wake |= {dis_rs3 == wake_rd_a[k], dis_rs2 == wake_rd_a[k], dis_rs1 == wake_rd_a[k]};
      end
    end
  end

  age_matrix_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .enq_en    (enq_fire),
    .enq_oh    (free_oh),
    .free_mask (free_mask),
    .valid     (valid_q),
    .elig      (elig),
    .oldest_oh (oldest_oh)
  );

  always_comb begin
    sel_uop = '0;
    rsv_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest_oh[i]) begin
        sel_uop = entry_q[i].uop;
        rsv_set = lat_oh[i];
      end
    end
  end

  // A selected op that the redirect squashes is dropped without reserving.
  assign sel_squash = |(oldest_oh & squash);
  assign issue      = (|oldest_oh) & ~sel_squash;
  assign free_mask  = squash | oldest_oh;
  assign wb_rsv_d   = wb_rsv_shift | (issue ? rsv_set : '0);

  always_comb begin
    new_entry.uop.fltop  = dis_fltop;
    new_entry.uop.rm     = dis_rm;
    new_entry.uop.rs1    = dis_rs1;
    new_entry.uop.rs2    = dis_rs2;
    new_entry.uop.rs3    = dis_rs3;
    new_entry.uop.rd     = dis_rd;
    new_entry.uop.robIdx = dis_robIdx;
    // rs3 is only read by the fused multiply-add family
    new_entry.rdy        = dis_rdy | dis_wake | {~is_madd_class(dis_fltop), 2'b00};
  end

  always_comb begin
    valid_d = valid_q & ~free_mask;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i]     = entry_q[i];
      entry_d[i].rdy = entry_q[i].rdy | wake_hit[i];
      if (enq_fire && free_oh[i]) begin
        valid_d[i] = 1'b1;
        entry_d[i] = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wb_rsv_q <= '0;
      iss_en_q <= 1'b0;
      iss_q    <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      wb_rsv_q <= wb_rsv_d;
      iss_en_q <= issue;
      if (issue) iss_q <= sel_uop;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  assign iss_en     = iss_en_q;
  assign iss_fltop  = iss_q.fltop;
  assign iss_rm     = iss_q.rm;
  assign iss_rs1    = iss_q.rs1;
  assign iss_rs2    = iss_q.rs2;
  assign iss_rs3    = iss_q.rs3;
  assign iss_rd     = iss_q.rd;
  assign iss_robIdx = iss_q.robIdx;

endmodule

// File: tb/tb_fma_issue_queue.sv
// Directed bench for fma_issue_queue: one task per scenario, inline checks.
module tb_fma_issue_queue;
  import fma_issue_queue_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         dis_en;
  logic                         dis_ready;
  logic [FLTOP_WIDTH-1:0]       dis_fltop;
  logic [2:0]                   dis_rm;
  logic [PREG_WIDTH-1:0]        dis_rs1, dis_rs2, dis_rs3;
  logic [2:0]                   dis_rdy;
  logic [PREG_WIDTH-1:0]        dis_rd;
  logic [ROB_WIDTH-1:0]         dis_robIdx;
  logic [3:0]                   wake_en;
  logic [4*PREG_WIDTH-1:0]      wake_rd;
  BackendCtrl                   backendCtrl;
  logic                         iss_en;
  logic [FLTOP_WIDTH-1:0]       iss_fltop;
  logic [2:0]                   iss_rm;
  logic [PREG_WIDTH-1:0]        iss_rs1, iss_rs2, iss_rs3, iss_rd;
  logic [ROB_WIDTH-1:0]         iss_robIdx;

  int checks = 0;
  int errors = 0;

  fma_issue_queue dut (
    .clk(clk), .rst(rst),
    .dis_en(dis_en), .dis_ready(dis_ready), .dis_fltop(dis_fltop), .dis_rm(dis_rm),
    .dis_rs1(dis_rs1), .dis_rs2(dis_rs2), .dis_rs3(dis_rs3), .dis_rdy(dis_rdy),
    .dis_rd(dis_rd), .dis_robIdx(dis_robIdx),
    .wake_en(wake_en), .wake_rd(wake_rd), .backendCtrl(backendCtrl),
    .iss_en(iss_en), .iss_fltop(iss_fltop), .iss_rm(iss_rm), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_rs3(iss_rs3), .iss_rd(iss_rd), .iss_robIdx(iss_robIdx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && iss_en)
      $display("issue rob=%0d op=%0d rs1=%0d rs2=%0d rs3=%0d rd=%0d",
               iss_robIdx, iss_fltop, iss_rs1, iss_rs2, iss_rs3, iss_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dis_en = 1'b0; dis_fltop = '0; dis_rm = '0; dis_rs1 = '0; dis_rs2 = '0; dis_rs3 = '0;
    dis_rdy = '0; dis_rd = '0; dis_robIdx = '0;
    wake_en = '0; wake_rd = '0; backendCtrl = '0;
  endtask

  task automatic drive_dis(input logic [3:0] op, input logic [2:0] rm,
                           input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3,
                           input logic [2:0] rdy, input logic [5:0] rd, input logic [5:0] rob);
    dis_en = 1'b1; dis_fltop = op; dis_rm = rm; dis_rs1 = rs1; dis_rs2 = rs2; dis_rs3 = rs3;
    dis_rdy = rdy; dis_rd = rd; dis_robIdx = rob;
  endtask

  task automatic set_wake(input int port, input logic [5:0] preg);
    wake_en[port] = 1'b1;
    wake_rd[port*PREG_WIDTH +: PREG_WIDTH] = preg;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (5) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({iss_en, dis_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_ctrl: iss_en=%0b dis_ready=%0b expected 0/1", iss_en, dis_ready);
    end
    checks++;
    if ({iss_fltop, iss_rm, iss_rs1, iss_rs2, iss_rs3, iss_rd, iss_robIdx} !== '0) begin
      errors++; $display("FAIL reset_fields: rob=%0d rd=%0d op=%0d expected all 0", iss_robIdx, iss_rd, iss_fltop);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({iss_en, dis_ready} !== 2'b01) begin
        errors++; $display("FAIL idle_%0d: iss_en=%0b dis_ready=%0b expected 0/1", c, iss_en, dis_ready);
      end
    end
  endtask

  task automatic test_mul_add();
    drive_dis(FLT_MUL, 3'd0, 6'd5, 6'd6, 6'd0, 3'b011, 6'd10, 6'd1);
    step();                                     // MUL selected this cycle
    drive_dis(FLT_ADD, 3'd0, 6'd1, 6'd2, 6'd0, 3'b111, 6'd11, 6'd2);
    step();
    idle_inputs();
    checks++;
    if ({iss_en, iss_robIdx, iss_fltop, iss_rs1, iss_rs2} !== {1'b1, 6'd1, 4'(FLT_MUL), 6'd5, 6'd6}) begin
      errors++; $display("FAIL mul_issue: en=%0b rob=%0d op=%0d rs1=%0d rs2=%0d expected 1/1/2/5/6",
                         iss_en, iss_robIdx, iss_fltop, iss_rs1, iss_rs2);
    end
    step();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL add_blocked_by_mul: iss_en=%0b rob=%0d expected 0", iss_en, iss_robIdx);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx, iss_rd} !== {1'b1, 6'd2, 6'd11}) begin
      errors++; $display("FAIL add_after_mul: en=%0b rob=%0d rd=%0d expected 1/2/11", iss_en, iss_robIdx, iss_rd);
    end
    step();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL mul_add_idle: iss_en=%0b expected 0", iss_en);
    end
    drain();
  endtask

  task automatic test_madd_wake();
    drive_dis(FLT_MADD, 3'd2, 6'd7, 6'd8, 6'd9, 3'b011, 6'd12, 6'd3);
    step();
    idle_inputs();
    set_wake(1, 6'd19);                         // unrelated preg
    step();
    idle_inputs();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL madd_wait: iss_en=%0b expected 0", iss_en);
    end
    set_wake(0, 6'd9);
    step();                                     // rs3 ready, MADD selected
    idle_inputs();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL madd_no_false_wake: iss_en=%0b expected 0", iss_en);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx, iss_fltop, iss_rs3, iss_rm} !== {1'b1, 6'd3, 4'(FLT_MADD), 6'd9, 3'd2}) begin
      errors++; $display("FAIL madd_issue: en=%0b rob=%0d op=%0d rs3=%0d rm=%0d expected 1/3/3/9/2",
                         iss_en, iss_robIdx, iss_fltop, iss_rs3, iss_rm);
    end
    step();
    drive_dis(FLT_ADD, 3'd0, 6'd1, 6'd2, 6'd0, 3'b111, 6'd13, 6'd4);
    step();                                     // ADD valid, blocked by MADD writeback
    idle_inputs();
    step();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL add_blocked_by_madd: iss_en=%0b rob=%0d expected 0", iss_en, iss_robIdx);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx} !== {1'b1, 6'd4}) begin
      errors++; $display("FAIL add_after_madd: en=%0b rob=%0d expected 1/4", iss_en, iss_robIdx);
    end
    drain();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dis_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready_%0d: dis_ready=%0b expected 1", i, dis_ready);
      end
      drive_dis(FLT_ADD, 3'd0, 6'd20, 6'd21, 6'd0, 3'b000, 6'(32 + i), 6'(i));
      step();
    end
    idle_inputs();
    checks++;
    if ({dis_ready, iss_en} !== 2'b00) begin
      errors++; $display("FAIL full: dis_ready=%0b iss_en=%0b expected 0/0", dis_ready, iss_en);
    end
    set_wake(0, 6'd20);
    set_wake(1, 6'd21);
    step();
    idle_inputs();
    checks++;
    if (dis_ready !== 1'b0) begin
      errors++; $display("FAIL full_during_select: dis_ready=%0b expected 0", dis_ready);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx, dis_ready} !== {1'b1, 6'd0, 1'b1}) begin
      errors++; $display("FAIL fill_first: en=%0b rob=%0d dis_ready=%0b expected 1/0/1", iss_en, iss_robIdx, dis_ready);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if ({iss_en, iss_robIdx} !== {1'b1, 6'(k)}) begin
        errors++; $display("FAIL fill_order_%0d: en=%0b rob=%0d expected 1/%0d", k, iss_en, iss_robIdx, k);
      end
    end
    step();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL fill_empty: iss_en=%0b expected 0", iss_en);
    end
    drain();
  endtask

  // younger op lands in a lower slot than an older waiting op
  task automatic test_age();
    drive_dis(FLT_ADD, 3'd0, 6'd1, 6'd2, 6'd0, 3'b111, 6'd1, 6'd10);
    step();
    drive_dis(FLT_ADD, 3'd0, 6'd40, 6'd40, 6'd0, 3'b000, 6'd2, 6'd11);
    step();
    checks++;
    if ({iss_en, iss_robIdx} !== {1'b1, 6'd10}) begin
      errors++; $display("FAIL age_first: en=%0b rob=%0d expected 1/10", iss_en, iss_robIdx);
    end
    drive_dis(FLT_ADD, 3'd0, 6'd40, 6'd40, 6'd0, 3'b000, 6'd3, 6'd12);
    step();
    idle_inputs();
    set_wake(3, 6'd40);
    step();
    idle_inputs();
    step();
    checks++;
    if ({iss_en, iss_robIdx} !== {1'b1, 6'd11}) begin
      errors++; $display("FAIL age_older: en=%0b rob=%0d expected 1/11", iss_en, iss_robIdx);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx} !== {1'b1, 6'd12}) begin
      errors++; $display("FAIL age_younger: en=%0b rob=%0d expected 1/12", iss_en, iss_robIdx);
    end
    drain();
  endtask

  task automatic test_redirect();
    drive_dis(FLT_ADD, 3'd0, 6'd50, 6'd50, 6'd0, 3'b000, 6'd1, 6'd2);
    step();
    drive_dis(FLT_ADD, 3'd0, 6'd50, 6'd50, 6'd0, 3'b000, 6'd2, 6'd4);
    step();
    drive_dis(FLT_ADD, 3'd0, 6'd50, 6'd50, 6'd0, 3'b000, 6'd3, 6'd6);
    step();
    drive_dis(FLT_ADD, 3'd0, 6'd1, 6'd2, 6'd0, 3'b111, 6'd4, 6'd5);
    step();                                     // rob5 selected while redirect fires
    drive_dis(FLT_ADD, 3'd0, 6'd1, 6'd2, 6'd0, 3'b111, 6'd5, 6'd1);
    backendCtrl.redirect    = 1'b1;
    backendCtrl.redirectIdx = 6'd3;
    step();
    idle_inputs();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL redirect_suppress: iss_en=%0b rob=%0d expected 0", iss_en, iss_robIdx);
    end
    set_wake(0, 6'd50);
    step();
    idle_inputs();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL redirect_dis_ignored: iss_en=%0b rob=%0d expected 0", iss_en, iss_robIdx);
    end
    step();
    checks++;
    if ({iss_en, iss_robIdx} !== {1'b1, 6'd2}) begin
      errors++; $display("FAIL redirect_survivor: en=%0b rob=%0d expected 1/2", iss_en, iss_robIdx);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (iss_en !== 1'b0) begin
        errors++; $display("FAIL redirect_squashed_%0d: iss_en=%0b rob=%0d expected 0", c, iss_en, iss_robIdx);
      end
    end
    drain();
  endtask

  task automatic test_bypass();
    drive_dis(FLT_ADD, 3'd1, 6'd12, 6'd13, 6'd0, 3'b010, 6'd14, 6'd20);
    set_wake(2, 6'd12);
    step();
    idle_inputs();
    step();
    checks++;
    if ({iss_en, iss_robIdx, iss_rs1, iss_rs2} !== {1'b1, 6'd20, 6'd12, 6'd13}) begin
      errors++; $display("FAIL bypass_issue: en=%0b rob=%0d rs1=%0d rs2=%0d expected 1/20/12/13",
                         iss_en, iss_robIdx, iss_rs1, iss_rs2);
    end
    step();
    checks++;
    if (iss_en !== 1'b0) begin
      errors++; $display("FAIL bypass_once: iss_en=%0b expected 0", iss_en);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_add();
    test_madd_wake();
    test_fill();
    test_age();
    test_redirect();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
